// File: rtl/wrsw_pstats_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wrsw_pstats_bank                                                       |
// | Per-port event counter bank with atomic snapshot and overflow IRQ.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module wrsw_pstats_bank #(
  parameter int g_nports    = 8,
  parameter int g_cnt_pp    = 17,
  parameter int g_cnt_width = 32,
  parameter int g_saturate  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [g_nports*g_cnt_pp-1:0] events_i,
  input  logic [2:0]                   wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [3:0]                   wb_sel_i,
  output logic                         wb_ack_o,
  output logic                         wb_stall_o,
  output logic                         irq_o
);

  localparam int                     c_ncnt     = g_nports * g_cnt_pp;
  localparam logic [g_cnt_width-1:0] c_ones     = '1;
  localparam logic [2:0]             c_adr_cr   = 3'd0;
  localparam logic [2:0]             c_adr_dr   = 3'd1;
  localparam logic [2:0]             c_adr_ovf  = 3'd2;
  localparam logic [2:0]             c_adr_imr  = 3'd3;
  localparam logic [2:0]             c_adr_sseq = 3'd4;

  logic                r_clr_on_snap;
  logic [7:0]          r_psel;
  logic [7:0]          r_csel;
  logic [g_nports-1:0] r_ovf;
  logic [g_nports-1:0] r_imr;
  logic [15:0]         r_sseq;
  logic                r_ack;
  logic                r_irq;
  logic [31:0]         r_dat;

  logic                w_acc;
  logic                w_rd;
  logic                w_wr;
  logic                w_cr_wr;
  logic                w_snap;
  logic                w_snap_clr;
  logic                w_cr_rst;
  logic                w_ovf_wr;
  logic                w_imr_wr;
  logic [g_nports-1:0] w_ovf_clr;
  logic [g_nports-1:0] w_ovf_set;
  logic [c_ncnt-1:0]   w_ovf_hit;
  logic [31:0]         w_dr_term [c_ncnt];
  logic [31:0]         w_dr;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  assign w_acc      = wb_cyc_i & wb_stb_i;
  assign w_rd       = w_acc & ~wb_we_i;
  assign w_wr       = w_acc & wb_we_i;
  assign w_cr_wr    = w_wr & (wb_adr_i == c_adr_cr);
  assign w_snap     = w_cr_wr & wb_dat_i[0];
  assign w_snap_clr = w_snap & wb_dat_i[1];
  assign w_cr_rst   = w_cr_wr & wb_dat_i[31];
  assign w_ovf_wr   = w_wr & (wb_adr_i == c_adr_ovf);
  assign w_imr_wr   = w_wr & (wb_adr_i == c_adr_imr);
  assign w_ovf_clr  = w_ovf_wr ? wb_dat_i[g_nports-1:0] : '0;
  assign w_unused   = &{1'b0, wb_sel_i, wb_dat_i};

  for (genvar gp = 0; gp < g_nports; gp++) begin : g_port
    for (genvar ge = 0; ge < g_cnt_pp; ge++) begin : g_cnt
      localparam int c_idx = gp * g_cnt_pp + ge;
      logic [g_cnt_width-1:0] r_live;
      logic [g_cnt_width-1:0] r_shadow;
      logic                   w_ev;

      assign w_ev             = events_i[c_idx];
      // An increment suppressed by RST or snapshot-clear never counts as overflow.
      assign w_ovf_hit[c_idx] = w_ev && (r_live == c_ones) && !w_cr_rst && !w_snap_clr;
      assign w_dr_term[c_idx] = ((r_psel == 8'(gp)) && (r_csel == 8'(ge))) ?
                                32'(r_shadow) : 32'd0;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_live   <= '0;
          r_shadow <= '0;
        end else begin
          if (w_snap)
            r_shadow <= r_live;
          if (w_cr_rst)
            r_live <= '0;
          else if (w_snap_clr)
            r_live <= g_cnt_width'(w_ev);
          else if (w_ev) begin
            if (r_live == c_ones)
              r_live <= (g_saturate != 0) ? c_ones : '0;
            else
              r_live <= r_live + 1'b1;
          end
        end
      end
    end
    assign w_ovf_set[gp] = |w_ovf_hit[gp*g_cnt_pp +: g_cnt_pp];
  end

  // Out-of-range selects match no term, so DR reads zero.
  always_comb begin
    w_dr = '0;
    for (int i = 0; i < c_ncnt; i++)
      w_dr = w_dr | w_dr_term[i];
  end

  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i)
      c_adr_cr:   w_rd_data = {8'h00, r_csel, r_psel, 6'h00, r_clr_on_snap, 1'b0};
      c_adr_dr:   w_rd_data = w_dr;
      c_adr_ovf:  w_rd_data = 32'(r_ovf);
      c_adr_imr:  w_rd_data = 32'(r_imr);
      c_adr_sseq: w_rd_data = {16'h0000, r_sseq};
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clr_on_snap <= 1'b0;
      r_psel        <= '0;
      r_csel        <= '0;
      r_ovf         <= '0;
      r_imr         <= '0;
      r_sseq        <= '0;
      r_ack         <= 1'b0;
      r_irq         <= 1'b0;
      r_dat         <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rd_data : 32'd0;
      r_irq <= |(r_ovf & r_imr);
      if (w_cr_wr) begin
        r_clr_on_snap <= wb_dat_i[1];
        r_psel        <= wb_dat_i[15:8];
        r_csel        <= wb_dat_i[23:16];
      end
      if (w_imr_wr)
        r_imr <= wb_dat_i[g_nports-1:0];
      if (w_cr_rst)
        r_ovf <= '0;
      else
        r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
      if (w_cr_rst)
        r_sseq <= '0;
      else if (w_snap)
        r_sseq <= r_sseq + 16'd1;
    end
  end

  assign wb_ack_o   = r_ack & ~rst_i;
  assign wb_dat_o   = rst_i ? 32'd0 : r_dat;
  assign wb_stall_o = 1'b0;
  assign irq_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wrsw_pstats_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_wrsw_pstats_bank                                                    |
// | Directed bench: a wrapping and a saturating 8-bit bank on one bus.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_wrsw_pstats_bank;

  localparam int c_np  = 8;
  localparam int c_pp  = 17;
  localparam int c_nev = c_np * c_pp;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [c_nev-1:0] events = '0;
  logic [2:0]       adr = '0;
  logic [31:0]      wdat = '0;
  logic             cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]       sel = 4'hF;
  logic [31:0]      dat_a, dat_b;
  logic             ack_a, ack_b, stall_a, stall_b, irq_a, irq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wrsw_pstats_bank #(.g_nports(c_np), .g_cnt_pp(c_pp), .g_cnt_width(8), .g_saturate(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .events_i(events), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_a), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_ack_o(ack_a), .wb_stall_o(stall_a), .irq_o(irq_a));

  wrsw_pstats_bank #(.g_nports(c_np), .g_cnt_pp(c_pp), .g_cnt_width(8), .g_saturate(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .events_i(events), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_b), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_ack_o(ack_b), .wb_stall_o(stall_b), .irq_o(irq_b));

  // All tasks start and end 1 ns after a rising edge.
  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] da, output logic [31:0] db);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    da = dat_a; db = dat_b;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic pulse(input int idx, input int n);
    events = c_nev'(1) << idx;
    repeat (n) @(posedge clk);
    #1;
    events = '0;
  endtask

  task automatic test_reset;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack_a); end
    checks++; if (dat_a !== 32'd0) begin errors++; $display("FAIL rst_dat: got %h want 0", dat_a); end
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_a); end
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_a); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 5; a++) begin
      wb_read(3'(a), ra, rb);
      checks++; if (ra !== 32'd0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", a, ra); end
    end
  endtask

  task automatic test_basic_count;
    logic [31:0] ra, rb;
    pulse(2*c_pp+5, 10);
    wb_write(3'd0, 32'h0005_0201);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd10) begin errors++; $display("FAIL basic_dr_wrap: got %0d want 10", ra); end
    checks++; if (rb !== 32'd10) begin errors++; $display("FAIL basic_dr_sat: got %0d want 10", rb); end
    wb_read(3'd0, ra, rb);
    checks++; if (ra !== 32'h0005_0200) begin errors++; $display("FAIL basic_cr: got %h want 00050200", ra); end
    wb_read(3'd4, ra, rb);
    checks++; if (ra !== 32'd1) begin errors++; $display("FAIL basic_sseq: got %0d want 1", ra); end
    wb_write(3'd0, 32'h0004_0200);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL basic_other1: got %0d want 0", ra); end
    wb_write(3'd0, 32'h0005_0300);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL basic_other2: got %0d want 0", ra); end
  endtask

  task automatic test_clr_on_snap;
    logic [31:0] ra, rb;
    wb_write(3'd0, 32'h8000_0000);
    pulse(0, 100);
    wb_write(3'd0, 32'h0000_0003);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd100) begin errors++; $display("FAIL cos_first: got %0d want 100", ra); end
    pulse(0, 40);
    wb_write(3'd0, 32'h0000_0003);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd40) begin errors++; $display("FAIL cos_second: got %0d want 40", ra); end
    wb_read(3'd4, ra, rb);
    checks++; if (ra !== 32'd2) begin errors++; $display("FAIL cos_sseq: got %0d want 2", ra); end
  endtask

  task automatic test_collisions;
    logic [31:0] ra, rb;
    pulse(0, 5);
    events = c_nev'(1);
    wb_write(3'd0, 32'h8000_0000);
    events = '0;
    wb_write(3'd0, 32'h0000_0001);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL coll_rst: got %0d want 0", ra); end
    pulse(0, 7);
    events = c_nev'(1);
    wb_write(3'd0, 32'h0000_0003);
    events = '0;
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd7) begin errors++; $display("FAIL coll_snap_old: got %0d want 7", ra); end
    wb_write(3'd0, 32'h0000_0001);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd1) begin errors++; $display("FAIL coll_snap_live: got %0d want 1", ra); end
    wb_read(3'd4, ra, rb);
    checks++; if (ra !== 32'd3) begin errors++; $display("FAIL coll_sseq: got %0d want 3", ra); end
  endtask

  task automatic test_overflow;
    logic [31:0] ra, rb;
    wb_write(3'd0, 32'h8000_0000);
    wb_write(3'd3, 32'h0000_0080);
    pulse(7*c_pp, 255);
    wb_read(3'd2, ra, rb);
    checks++; if (ra !== 32'd0 || rb !== 32'd0) begin errors++; $display("FAIL ovf_early: got %h/%h want 0/0", ra, rb); end
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq_a); end
    pulse(7*c_pp, 1);
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_same_edge: got %b want 0", irq_a); end
    @(posedge clk); #1;
    checks++; if (irq_a !== 1'b1 || irq_b !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b/%b want 1/1", irq_a, irq_b); end
    pulse(7*c_pp, 1);
    wb_write(3'd0, 32'h0000_0701);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd1) begin errors++; $display("FAIL wrap_dr: got %0d want 1", ra); end
    checks++; if (rb !== 32'hFF) begin errors++; $display("FAIL sat_dr: got %h want ff", rb); end
    wb_read(3'd2, ra, rb);
    checks++; if (ra !== 32'h80 || rb !== 32'h80) begin errors++; $display("FAIL ovf_flag: got %h/%h want 80/80", ra, rb); end
    wb_write(3'd2, 32'h0000_0080);
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq_a); end
    @(posedge clk); #1;
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b/%b want 0/0", irq_a, irq_b); end
    wb_read(3'd2, ra, rb);
    checks++; if (ra !== 32'd0 || rb !== 32'd0) begin errors++; $display("FAIL ovf_cleared: got %h/%h want 0/0", ra, rb); end
    // Saturated bank overflows again while the bit is being cleared.
    events = c_nev'(1) << (7*c_pp);
    wb_write(3'd2, 32'h0000_0080);
    events = '0;
    wb_read(3'd2, ra, rb);
    checks++; if (ra !== 32'd0 || rb !== 32'h80) begin errors++; $display("FAIL ovf_set_wins: got %h/%h want 0/80", ra, rb); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ra, rb;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd1;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b1 || dat_a !== 32'd1 || dat_b !== 32'hFF) begin errors++; $display("FAIL b2b_dr: ack %b data %h/%h want 1 1/ff", ack_a, dat_a, dat_b); end
    adr = 3'd2;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b1 || dat_a !== 32'd0 || dat_b !== 32'h80) begin errors++; $display("FAIL b2b_ovf: ack %b data %h/%h want 1 0/80", ack_a, dat_a, dat_b); end
    adr = 3'd4;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b1 || dat_a !== 32'd1) begin errors++; $display("FAIL b2b_sseq: ack %b data %h want 1 1", ack_a, dat_a); end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack_a !== 1'b0 || dat_a !== 32'd0) begin errors++; $display("FAIL b2b_idle: ack %b data %h want 0 0", ack_a, dat_a); end
    wb_write(3'd0, 32'h0000_2000);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL psel_oor: got %h want 0", ra); end
    wb_write(3'd0, 32'h0011_0600);
    wb_read(3'd1, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL csel_oor: got %h want 0", ra); end
    wb_write(3'd5, 32'hFFFF_FFFF);
    wb_read(3'd5, ra, rb);
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL reserved: got %h want 0", ra); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] ra, rb;
    wb_write(3'd3, 32'h0000_000F);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd3;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (ack_a !== 1'b0 || dat_a !== 32'd0) begin errors++; $display("FAIL mid_ack: ack %b data %h want 0 0", ack_a, dat_a); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      wb_read(3'(a), ra, rb);
      checks++; if (ra !== 32'd0 || rb !== 32'd0) begin errors++; $display("FAIL mid_reg%0d: got %h/%h want 0/0", a, ra, rb); end
    end
    checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b want 0", irq_b); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_clr_on_snap();
    test_collisions();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/wrsw_pstats_bank.md
# wrsw_pstats_bank

Parametrised per-port event statistics bank for the switch: counts single-cycle event pulses from `g_nports` ports, each with `g_cnt_pp` event lines, into `g_cnt_width`-bit counters. It adds atomic snapshotting, optional clear-on-snapshot, selectable wrap or saturate overflow, and per-port overflow interrupts. Counters are read through a pipelined Wishbone slave. It sits between the port event sources and the CPU register bus, where the earlier counter bank sat.

## Interface
- `g_nports`, 8, number of ports (1..16).
- `g_cnt_pp`, 17, event lines (counters) per port (1..64).
- `g_cnt_width`, 32, counter width in bits (8..32).
- `g_saturate`, 0, overflow mode:
  - 0: the counter wraps to 0.
  - 1: the counter holds its all-ones value.
- `clk_i` in 1: system clock; all logic runs on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `events_i` in `g_nports*g_cnt_pp`: event pulses. Bit `p*g_cnt_pp+e` is event `e` of port `p`.
- `wb_adr_i` in 3: word address. Byte offset = `wb_adr_i`×4.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: Wishbone cycle, strobe and write enable.
- `wb_sel_i` in 4: ignored; every access is a full word.
- `wb_ack_o` out 1: access acknowledge.
- `wb_stall_o` out 1: stall; tied to 0.
- `irq_o` out 1: overflow interrupt, registered.

## Operation
- **Live counters.** Each asserted `events_i` bit increments its counter by 1 at that clock edge.
- **Overflow.** An event arriving at a counter that holds all-ones sets bit p of OVF for port p. The counter then becomes 0 if `g_saturate`=0, or stays all-ones if `g_saturate`=1.
- **Shadow bank.** A second counter array, updated only by snapshot. DR always reads from the shadow bank.
- **Register map:**
  - 0x00 CR, read/write.
    - [0] SNAP: write 1 to take a snapshot; self-clearing, reads 0.
    - [1] CLR_ON_SNAP: when set, a snapshot also zeroes the live counters.
    - [15:8] PSEL: port select.
    - [23:16] CSEL: counter select.
    - [31] RST: write 1 to clear all live counters and OVF; self-clearing, reads 0.
  - 0x04 DR, read-only: shadow[PSEL][CSEL], zero-extended to 32 bits. Reads 0 when PSEL≥`g_nports` or CSEL≥`g_cnt_pp`.
  - 0x08 OVF: [g_nports-1:0] per-port overflow flags. Writing 1 to a bit clears it.
  - 0x0C IMR, read/write: per-port interrupt mask.
  - 0x10 SSEQ, read-only: [15:0] snapshot count, wraps at 0xFFFF→0, cleared by RST.
  - 0x14–0x1C: reserved. Reads return 0; writes are ignored.
- **Interrupt.** `irq_o` = OR over all ports of (OVF & IMR), registered.
- **Simultaneous events, priority highest first:**
  - `rst_i` > CR.RST > snapshot-with-clear > event increment.
  - RST in the same cycle as an event: the counter ends at 0.
  - Snapshot in the same cycle as an event: the shadow captures the value before the increment. With CLR_ON_SNAP set, the live counter ends at 1.
  - An OVF set (by an overflow) and a clear (by a 1 written to that bit) in the same cycle: the flag ends set.

## Timing
- **Reset values.** `rst_i` sampled high clears all live counters, shadow counters, CR, OVF, IMR and SSEQ. Outputs during and after reset: `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0, `wb_stall_o`=0.
- **Access timing.** An access is accepted at edge T when `wb_cyc_i & wb_stb_i` are high.
  - `wb_ack_o` is high for exactly one cycle, T+1.
  - For reads, `wb_dat_o` is valid in T+1; it returns 0 at any other time.
  - Back-to-back accesses are accepted every cycle.
- **Write effect.** Writes take effect at edge T.
  - Snapshot and RST act on the live values as they stood before edge T.
  - A DR read accepted at T+1 already returns the new shadow value.
- **CR and DR ordering.** A CR write at T followed by a DR read at T+1 uses the new PSEL/CSEL.
- **Event timing.** An event sampled at edge T is visible in a snapshot taken at T+1 or later.
- **Interrupt timing.** An overflow at edge T sets OVF at T; `irq_o` rises at T+1. Clearing the OVF bit or the IMR bit at edge T drops `irq_o` at T+1.
- **Reset mid-access.** If `rst_i` is high during a pending ack cycle, the ack is suppressed.

## Test plan
- **Basic count.** Pulse port 2 / event 5 ten times, then write CR=0x00050201 and read DR → 10. SSEQ → 1. All other counters read 0.
- **Wrap overflow.** `g_cnt_width`=8, `g_saturate`=0. Drive port 7 / event 0 with 257 pulses, IMR=0x80, then snapshot → DR=1, OVF=0x80, `irq_o`=1 one cycle after the 256th pulse. Writing OVF=0x80 drops `irq_o` the next cycle.
- **Saturate overflow.** Same stimulus with `g_saturate`=1 → DR=0xFF, OVF=0x80.
- **Clear-on-snapshot.** 100 pulses, then CR=0x3; 40 more pulses, then CR=0x3 again → DR reads 100, then 40.
- **Collisions.** Event in the same cycle as CR.RST → counter reads 0 after the next snapshot. Event in the same cycle as snapshot-with-clear → shadow holds the old value n, live counter 1.
- **Bus and reset.** Back-to-back reads of 0x04, 0x08, 0x10 → one ack per cycle. Out-of-range PSEL=0x20 → DR=0. `rst_i` pulse mid-sequence → every register reads its reset value afterwards.
